hack_boot_loader: RTL and testbench

Boot-time sequencer for the Hack computer. It holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, and writes it word by word into the instruction ROM. It checks the image length and checksum, then releases the CPU to run from address 0. It sits between an external byte source (UART receiver or host FIFO) and the ROM write port / CPU reset input.

---
 rtl/hack_boot_loader_if.sv | 22 ++
 rtl/hack_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_hack_boot_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_boot_loader_if.sv
// Byte-stream input and ROM write port of the Hack boot loader.
// The loader takes the slave view; the byte source / ROM side takes the master view.
interface hack_boot_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              rom_we;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, rom_addr, rom_wdata, rom_we
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, rom_addr, rom_wdata, rom_we
  );
endinterface

// File: rtl/hack_boot_loader.sv
// Boot-time sequencer: holds the Hack CPU in reset, streams a length-prefixed,
// checksummed image into instruction ROM, then releases the CPU.
module hack_boot_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 32768
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  hack_boot_loader_if.slave bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t              r_state,     w_state_nx;
  logic [WORD_W-1:0]   r_len,       w_len_nx;
  logic [BYTE_W-1:0]   r_hi,        w_hi_nx;
  logic [BYTE_W-1:0]   r_sum,       w_sum_nx;
  logic [ADDR_W-1:0]   r_index,     w_index_nx;
  logic [WORD_W-1:0]   r_wcount,    w_wcount_nx;
  logic                r_rx_ready,  w_rx_ready_nx;
  logic                r_rom_we,    w_rom_we_nx;
  logic [ADDR_W-1:0]   r_rom_addr,  w_rom_addr_nx;
  logic [WORD_W-1:0]   r_rom_wdata, w_rom_wdata_nx;
  logic                r_cpu_reset, w_cpu_reset_nx;
  logic                r_busy,      w_busy_nx;
  logic                r_done,      w_done_nx;
  logic                r_error,     w_error_nx;

  logic                w_fire;
  logic [WORD_W-1:0]   w_len_full;
  logic [WORD_W-1:0]   w_wcount_inc;

  // r_rx_ready always mirrors the current state, so it gates byte acceptance
  assign w_fire       = bus.rx_valid & r_rx_ready;
  assign w_len_full   = {r_len[WORD_W-1:BYTE_W], bus.rx_data};
  assign w_wcount_inc = r_wcount + WORD_W'(1);

  always_comb begin
    w_state_nx     = r_state;
    w_len_nx       = r_len;
    w_hi_nx        = r_hi;
    w_sum_nx       = r_sum;
    w_index_nx     = r_index;
    w_wcount_nx    = r_wcount;
    w_rom_we_nx    = 1'b0;
    w_rom_addr_nx  = r_rom_addr;
    w_rom_wdata_nx = r_rom_wdata;
    w_rx_ready_nx  = 1'b0;
    w_cpu_reset_nx = 1'b1;
    w_busy_nx      = 1'b0;
    w_done_nx      = 1'b0;
    w_error_nx     = 1'b0;

    unique case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          w_state_nx  = S_LEN_HI;
          w_index_nx  = '0;
          w_sum_nx    = '0;
          w_wcount_nx = '0;
        end
      end
      S_LEN_HI: begin
        if (w_fire) begin
          w_len_nx   = {bus.rx_data, r_len[BYTE_W-1:0]};
          w_state_nx = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_fire) begin
          w_len_nx = w_len_full;
          if (w_len_full == '0 || 32'(w_len_full) > 32'(MAX_WORDS)) begin
            w_state_nx = S_ERR;
          end else begin
            w_state_nx = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_fire) begin
          w_hi_nx    = bus.rx_data;
          w_sum_nx   = r_sum + bus.rx_data;
          w_state_nx = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_fire) begin
          w_sum_nx       = r_sum + bus.rx_data;
          w_rom_we_nx    = 1'b1;
          w_rom_addr_nx  = r_index;
          w_rom_wdata_nx = {r_hi, bus.rx_data};
          w_state_nx     = S_WRITE;
        end
      end
      S_WRITE: begin
        w_index_nx  = r_index + ADDR_W'(1);
        w_wcount_nx = w_wcount_inc;
        w_state_nx  = (w_wcount_inc == r_len) ? S_CHK : S_DATA_HI;
      end
      S_CHK: begin
        if (w_fire) begin
          w_state_nx = (bus.rx_data == r_sum) ? S_RUN : S_ERR;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Status outputs are decoded from the state being entered, then registered
    w_rx_ready_nx  = (w_state_nx inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK});
    w_busy_nx      = (w_state_nx inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK});
    w_cpu_reset_nx = (w_state_nx != S_RUN);
    w_done_nx      = (w_state_nx == S_RUN);
    w_error_nx     = (w_state_nx == S_ERR);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_hi        <= '0;
      r_sum       <= '0;
      r_index     <= '0;
      r_wcount    <= '0;
      r_rx_ready  <= 1'b0;
      r_rom_we    <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_len       <= w_len_nx;
      r_hi        <= w_hi_nx;
      r_sum       <= w_sum_nx;
      r_index     <= w_index_nx;
      r_wcount    <= w_wcount_nx;
      r_rx_ready  <= w_rx_ready_nx;
      r_rom_we    <= w_rom_we_nx;
      r_rom_addr  <= w_rom_addr_nx;
      r_rom_wdata <= w_rom_wdata_nx;
      r_cpu_reset <= w_cpu_reset_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_error     <= w_error_nx;
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.rom_we    = r_rom_we;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_wdata = r_rom_wdata;
  assign cpu_reset     = r_cpu_reset;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign word_count    = r_wcount;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: a full-size instance for the stream
// scenarios and a 16-word instance for the exact length boundary.
module tb_hack_boot_loader;

  logic        CLK;
  logic        reset_n;
  logic        start;
  logic        s_start;
  logic        cpu_reset, busy, done, error;
  logic [15:0] word_count;
  logic        s_cpu_reset, s_busy, s_done, s_error;
  logic [15:0] s_word_count;

  hack_boot_loader_if #(.ADDR_W(15)) bus ();
  hack_boot_loader_if #(.ADDR_W(4))  sbus ();

  hack_boot_loader #(.ADDR_W(15), .MAX_WORDS(32768)) u_dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  hack_boot_loader #(.ADDR_W(4), .MAX_WORDS(16)) u_small (
    .CLK(CLK), .reset_n(reset_n), .start(s_start), .bus(sbus),
    .cpu_reset(s_cpu_reset), .busy(s_busy), .done(s_done), .error(s_error),
    .word_count(s_word_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          consec_we = 0;
  logic        prev_we = 1'b0;
  logic        s_prev_we = 1'b0;
  logic [14:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [3:0]  s_addr_q[$];
  logic [15:0] s_data_q[$];

  // ROM-side monitor: logs every write strobe and flags back-to-back strobes
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus.rom_we) begin
      wr_addr_q.push_back(bus.rom_addr);
      wr_data_q.push_back(bus.rom_wdata);
    end
    if (sbus.rom_we) begin
      s_addr_q.push_back(sbus.rom_addr);
      s_data_q.push_back(sbus.rom_wdata);
    end
    if ((bus.rom_we && prev_we) || (sbus.rom_we && s_prev_we)) consec_we <= consec_we + 1;
    prev_we   <= bus.rom_we;
    s_prev_we <= sbus.rom_we;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = (bus.rx_ready === 1'b1);
      @(posedge CLK); #1;
    end
    if (!ok) begin n_bad++; $display("FAIL send_timeout: byte %h not accepted, required acceptance within 20 cycles", b); end
  endtask

  task automatic send_s(input logic [7:0] b);
    bit ok = 1'b0;
    sbus.rx_data  = b;
    sbus.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = (sbus.rx_ready === 1'b1);
      @(posedge CLK); #1;
    end
    if (!ok) begin n_bad++; $display("FAIL send_s_timeout: byte %h not accepted, required acceptance within 20 cycles", b); end
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    @(posedge CLK); #1;
    reset_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if ({cpu_reset, bus.rx_ready, bus.rom_we, busy, done, error} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags: {cpu_reset,rx_ready,rom_we,busy,done,error}=%b required 100000",
                        {cpu_reset, bus.rx_ready, bus.rom_we, busy, done, error}); end
    n_vec++; if (bus.rom_addr !== 15'h0 || bus.rom_wdata !== 16'h0 || word_count !== 16'h0) begin
      n_bad++; $display("FAIL reset_values: addr=%h wdata=%h word_count=%h required 0 0 0",
                        bus.rom_addr, bus.rom_wdata, word_count); end
    n_vec++; if (s_cpu_reset !== 1'b1 || s_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_small: cpu_reset=%b busy=%b required 1 0", s_cpu_reset, s_busy); end
    repeat (2) @(posedge CLK);
    #1 reset_n = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if (bus.rx_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_hold: rx_ready=%b busy=%b required 0 0", bus.rx_ready, busy); end
  endtask

  task automatic test_nominal();
    logic [7:0] s [7];
    int w0, c0;
    s = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hE3, 8'h08, 8'hFB};
    w0 = wr_addr_q.size();
    pulse_start();
    n_vec++; if (bus.rx_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1) begin
      n_bad++; $display("FAIL nominal_after_start: rx_ready=%b busy=%b cpu_reset=%b required 1 1 1",
                        bus.rx_ready, busy, cpu_reset); end
    c0 = cyc;
    for (int k = 0; k < 7; k++) send_byte(s[k]);
    bus.rx_valid = 1'b0;
    n_vec++; if (cyc - c0 !== 9) begin
      n_bad++; $display("FAIL nominal_cycles: got %0d cycles after start, required 9", cyc - c0); end
    n_vec++; if (wr_addr_q.size() !== w0 + 2) begin
      n_bad++; $display("FAIL nominal_write_count: got %0d writes, required 2", wr_addr_q.size() - w0); end
    n_vec++; if (wr_addr_q[w0] !== 15'h0 || wr_data_q[w0] !== 16'h0010) begin
      n_bad++; $display("FAIL nominal_word0: addr=%h data=%h required 0000 0010", wr_addr_q[w0], wr_data_q[w0]); end
    n_vec++; if (wr_addr_q[w0+1] !== 15'h1 || wr_data_q[w0+1] !== 16'hE308) begin
      n_bad++; $display("FAIL nominal_word1: addr=%h data=%h required 0001 e308", wr_addr_q[w0+1], wr_data_q[w0+1]); end
    n_vec++; if ({cpu_reset, done, error, busy} !== 4'b0100 || word_count !== 16'd2) begin
      n_bad++; $display("FAIL nominal_run: {cpu_reset,done,error,busy}=%b word_count=%0d required 0100 2",
                        {cpu_reset, done, error, busy}, word_count); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s [7];
    int w0;
    s = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hE3, 8'h08, 8'hFA};
    w0 = wr_addr_q.size();
    pulse_start();
    n_vec++; if (cpu_reset !== 1'b1 || done !== 1'b0 || word_count !== 16'd0) begin
      n_bad++; $display("FAIL restart_from_run: cpu_reset=%b done=%b word_count=%0d required 1 0 0",
                        cpu_reset, done, word_count); end
    for (int k = 0; k < 7; k++) send_byte(s[k]);
    bus.rx_valid = 1'b0;
    n_vec++; if ({error, cpu_reset, done} !== 3'b110 || wr_addr_q.size() !== w0 + 2) begin
      n_bad++; $display("FAIL badsum_err: {error,cpu_reset,done}=%b writes=%0d required 110 2",
                        {error, cpu_reset, done}, wr_addr_q.size() - w0); end
    s[6] = 8'hFB;
    pulse_start();
    n_vec++; if (error !== 1'b0) begin
      n_bad++; $display("FAIL badsum_restart_clear: error=%b required 0", error); end
    for (int k = 0; k < 7; k++) send_byte(s[k]);
    bus.rx_valid = 1'b0;
    n_vec++; if ({done, error, cpu_reset} !== 3'b100) begin
      n_bad++; $display("FAIL badsum_recover: {done,error,cpu_reset}=%b required 100", {done, error, cpu_reset}); end
  endtask

  task automatic test_len_limits();
    int w0;
    w0 = wr_addr_q.size();
    pulse_start(); send_byte(8'h00); send_byte(8'h00); bus.rx_valid = 1'b0;
    n_vec++; if (error !== 1'b1 || busy !== 1'b0 || wr_addr_q.size() !== w0) begin
      n_bad++; $display("FAIL len_zero: error=%b busy=%b writes=%0d required 1 0 0", error, busy, wr_addr_q.size() - w0); end
    pulse_start(); send_byte(8'h80); send_byte(8'h01); bus.rx_valid = 1'b0;
    n_vec++; if (error !== 1'b1 || cpu_reset !== 1'b1 || wr_addr_q.size() !== w0) begin
      n_bad++; $display("FAIL len_8001: error=%b cpu_reset=%b writes=%0d required 1 1 0",
                        error, cpu_reset, wr_addr_q.size() - w0); end
    pulse_start(); send_byte(8'h80); send_byte(8'h00); bus.rx_valid = 1'b0;
    n_vec++; if (error !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL len_8000_accept: error=%b busy=%b rx_ready=%b required 0 1 1", error, busy, bus.rx_ready); end
    send_byte(8'h12); send_byte(8'h34); bus.rx_valid = 1'b0;
    @(posedge CLK); #1;
    n_vec++; if (wr_addr_q.size() !== w0 + 1 || wr_addr_q[w0] !== 15'h0 || wr_data_q[w0] !== 16'h1234 || word_count !== 16'd1) begin
      n_bad++; $display("FAIL len_8000_first_word: writes=%0d addr=%h data=%h word_count=%0d required 1 0000 1234 1",
                        wr_addr_q.size() - w0, wr_addr_q[w0], wr_data_q[w0], word_count); end
    apply_reset();
  endtask

  task automatic test_len_boundary();
    logic [7:0] sum, hi, lo;
    int w0;
    w0  = s_addr_q.size();
    sum = 8'h00;
    s_start = 1'b1; @(posedge CLK); #1; s_start = 1'b0;
    send_s(8'h00); send_s(8'h10);
    for (int i = 0; i < 16; i++) begin
      hi  = 8'(i * 17);
      lo  = 8'h5A ^ 8'(i);
      sum = sum + hi + lo;
      send_s(hi); send_s(lo);
    end
    send_s(sum);
    sbus.rx_valid = 1'b0;
    n_vec++; if ({s_done, s_error} !== 2'b10 || s_word_count !== 16'd16 || s_addr_q.size() !== w0 + 16) begin
      n_bad++; $display("FAIL bound_max_run: {done,error}=%b word_count=%0d writes=%0d required 10 16 16",
                        {s_done, s_error}, s_word_count, s_addr_q.size() - w0); end
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (s_addr_q[w0+i] !== 4'(i) || s_data_q[w0+i] !== {8'(i * 17), 8'h5A ^ 8'(i)}) begin
        n_bad++; $display("FAIL bound_word%0d: addr=%h data=%h required %h %h", i, s_addr_q[w0+i], s_data_q[w0+i],
                          4'(i), {8'(i * 17), 8'h5A ^ 8'(i)}); end
    end
    s_start = 1'b1; @(posedge CLK); #1; s_start = 1'b0;
    send_s(8'h00); send_s(8'h11);
    sbus.rx_valid = 1'b0;
    n_vec++; if (s_error !== 1'b1 || s_busy !== 1'b0 || s_addr_q.size() !== w0 + 16) begin
      n_bad++; $display("FAIL bound_over: error=%b busy=%b writes=%0d required 1 0 16",
                        s_error, s_busy, s_addr_q.size() - w0); end
  endtask

  task automatic test_gaps();
    logic [7:0] s [9];
    int w0, gap;
    s  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBD};
    w0 = wr_addr_q.size();
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      gap = (k == 4 || k == 6 || k == 8) ? 0 : (k % 3);
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge CLK); #1; end
      send_byte(s[k]);
      if (k == 3 || k == 5 || k == 7) begin
        bus.rx_data  = s[k+1];
        bus.rx_valid = 1'b1;
        n_vec++; if (bus.rx_ready !== 1'b0 || bus.rom_we !== 1'b1 || word_count !== 16'((k - 3) / 2)) begin
          n_bad++; $display("FAIL gap_write_hold%0d: rx_ready=%b rom_we=%b word_count=%0d required 0 1 %0d",
                            k, bus.rx_ready, bus.rom_we, word_count, (k - 3) / 2); end
      end
    end
    bus.rx_valid = 1'b0;
    n_vec++; if (done !== 1'b1 || word_count !== 16'd3 || wr_addr_q.size() !== w0 + 3) begin
      n_bad++; $display("FAIL gap_run: done=%b word_count=%0d writes=%0d required 1 3 3",
                        done, word_count, wr_addr_q.size() - w0); end
    n_vec++; if (wr_data_q[w0] !== 16'h1234 || wr_data_q[w0+1] !== 16'hABCD || wr_data_q[w0+2] !== 16'h00FF ||
                 wr_addr_q[w0+2] !== 15'h2) begin
      n_bad++; $display("FAIL gap_contents: data=%h %h %h last_addr=%h required 1234 abcd 00ff 0002",
                        wr_data_q[w0], wr_data_q[w0+1], wr_data_q[w0+2], wr_addr_q[w0+2]); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s [11];
    int w0;
    s = '{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h54};
    pulse_start();
    for (int k = 0; k < 9; k++) send_byte(s[k]);
    bus.rx_valid = 1'b0;
    n_vec++; if (word_count !== 16'd3 || bus.rom_addr !== 15'h2 || bus.rom_wdata !== 16'h3333) begin
      n_bad++; $display("FAIL midreset_pre: word_count=%0d addr=%h wdata=%h required 3 0002 3333",
                        word_count, bus.rom_addr, bus.rom_wdata); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({cpu_reset, bus.rx_ready, bus.rom_we, busy, done, error} !== 6'b100000 ||
                 bus.rom_addr !== 15'h0 || bus.rom_wdata !== 16'h0 || word_count !== 16'h0) begin
      n_bad++; $display("FAIL midreset_async: flags=%b addr=%h wdata=%h word_count=%h required 100000 0 0 0",
                        {cpu_reset, bus.rx_ready, bus.rom_we, busy, done, error}, bus.rom_addr, bus.rom_wdata, word_count); end
    @(posedge CLK); #1;
    reset_n = 1'b1;
    w0 = wr_addr_q.size();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    bus.rx_valid = 1'b0;
    n_vec++; if (bus.rx_ready !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() !== w0) begin
      n_bad++; $display("FAIL midreset_idle: rx_ready=%b busy=%b writes=%0d required 0 0 0",
                        bus.rx_ready, busy, wr_addr_q.size() - w0); end
    pulse_start();
    send_byte(s[0]); send_byte(s[1]);
    bus.rx_valid = 1'b0;
    pulse_start();
    n_vec++; if (busy !== 1'b1 || bus.rx_ready !== 1'b1 || error !== 1'b0) begin
      n_bad++; $display("FAIL midreset_start_ignored: busy=%b rx_ready=%b error=%b required 1 1 0", busy, bus.rx_ready, error); end
    for (int k = 2; k < 11; k++) send_byte(s[k]);
    bus.rx_valid = 1'b0;
    n_vec++; if ({done, error, cpu_reset} !== 3'b100 || word_count !== 16'd4 || wr_addr_q.size() !== w0 + 4) begin
      n_bad++; $display("FAIL midreset_reload: {done,error,cpu_reset}=%b word_count=%0d writes=%0d required 100 4 4",
                        {done, error, cpu_reset}, word_count, wr_addr_q.size() - w0); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (wr_addr_q[w0+i] !== 15'(i) || wr_data_q[w0+i] !== {2{s[2+2*i]}}) begin
        n_bad++; $display("FAIL midreset_word%0d: addr=%h data=%h required %h %h", i, wr_addr_q[w0+i], wr_data_q[w0+i],
                          15'(i), {2{s[2+2*i]}}); end
    end
  endtask

  initial begin
    start         = 1'b0;
    s_start       = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    sbus.rx_data  = 8'h00;
    sbus.rx_valid = 1'b0;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_len_limits();
    test_len_boundary();
    test_gaps();
    test_mid_reset();
    n_vec++; if (consec_we !== 0) begin
      n_bad++; $display("FAIL rom_we_spacing: %0d back-to-back write strobes, required 0", consec_we); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
